// File: rtl/aes_pkg.sv
// ============================================================================
// Module : aes_pkg
// Brief  : Shared AES-128 key-schedule constants, FSM state type, S-box table.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package aes_pkg;

    localparam int AES_NR    = 10;
    localparam int AES_KEY_W = 128;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        EXPAND = 1'b1
    } state_t;

    localparam logic [7:0] RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // {a,b,c,d} -> {b,c,d,a}
    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/aes_sbox_word.sv
// ============================================================================
// Module : aes_sbox_word
// Brief  : Combinational 32-bit SubWord, four parallel forward S-box lookups.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module aes_sbox_word
    import aes_pkg::*;
(
    input  logic [31:0] word_in,
    output logic [31:0] word_out
);

    for (genvar i = 0; i < 4; i++) begin : g_byte
        assign word_out[8*i +: 8] = SBOX[word_in[8*i +: 8]];
    end

endmodule

`default_nettype wire

// File: rtl/aes_key_expand_seq.sv
// ============================================================================
// Module : aes_key_expand_seq
// Brief  : Iterative AES-128 key schedule, one round key per clock, 11 stored.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module aes_key_expand_seq
    import aes_pkg::*;
#(
    parameter int NR    = AES_NR,
    parameter int KEY_W = AES_KEY_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [KEY_W-1:0]        key_in,
    output logic                    busy,
    output logic                    done,
    output logic                    keys_valid,
    output logic [(NR+1)*KEY_W-1:0] round_keys,
    input  logic [3:0]              rd_idx,
    output logic [KEY_W-1:0]        rd_key
);

    localparam logic [3:0] C_LAST_RND = 4'(NR);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0]       r_rnd;
    logic             r_busy;
    logic             r_done;
    logic             r_keys_valid;
    logic [KEY_W-1:0] r_rk [0:NR];

    logic             w_load;
    logic             w_step;
    logic             w_last;
    logic [KEY_W-1:0] w_prev;
    logic [KEY_W-1:0] w_next;
    logic [7:0]       w_rcon;
    logic [31:0]      w_sub;
    logic [31:0]      w_t;
    logic [31:0]      w_n0;
    logic [31:0]      w_n1;
    logic [31:0]      w_n2;
    logic [31:0]      w_n3;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = EXPAND;
                end
            end
            EXPAND: begin
                w_step = 1'b1;
                if (r_rnd == C_LAST_RND) begin
                    w_last      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // ---------------- round function ----------------
    // r_rnd is 0 only after reset, where the result is never written
    always_comb begin
        w_prev = '0;
        w_rcon = 8'h00;
        if (r_rnd != 4'd0 && r_rnd <= C_LAST_RND) begin
            w_prev = r_rk[r_rnd - 4'd1];
            w_rcon = RCON[r_rnd];
        end
    end

    aes_sbox_word u_sbox (
        .word_in  (rot_word(w_prev[31:0])),
        .word_out (w_sub)
    );

    assign w_t    = w_sub ^ {w_rcon, 24'h0};
    assign w_n0   = w_prev[127:96] ^ w_t;
    assign w_n1   = w_prev[95:64]  ^ w_n0;
    assign w_n2   = w_prev[63:32]  ^ w_n1;
    assign w_n3   = w_prev[31:0]   ^ w_n2;
    assign w_next = {w_n0, w_n1, w_n2, w_n3};

    // ---------------- key store and status ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rnd        <= 4'd0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_keys_valid <= 1'b0;
            for (int i = 0; i <= NR; i++) begin
                r_rk[i] <= '0;
            end
        end else begin
            r_done <= w_last;
            if (w_load) begin
                r_rk[0]      <= key_in;
                r_rnd        <= 4'd1;
                r_keys_valid <= 1'b0;
                r_busy       <= 1'b1;
            end
            if (w_step) begin
                r_rk[r_rnd] <= w_next;
                if (w_last) begin
                    r_busy       <= 1'b0;
                    r_keys_valid <= 1'b1;
                end else begin
                    r_rnd <= r_rnd + 4'd1;
                end
            end
        end
    end

    // ---------------- outputs ----------------
    assign busy       = r_busy;
    assign done       = r_done;
    assign keys_valid = r_keys_valid;

    for (genvar i = 0; i <= NR; i++) begin : g_flat
        assign round_keys[KEY_W*(NR-i) +: KEY_W] = r_rk[i];
    end

    assign rd_key = (rd_idx <= C_LAST_RND) ? r_rk[rd_idx] : '0;

endmodule

`default_nettype wire
